// File: rtl/tick_rate_controller_pkg.sv
// Shared types for the tick rate controller: rate FSM states and transition helpers.
// The FSM only commits a rate change on a slow-period boundary, where both rates tick together.
package tick_rate_controller_pkg;

  typedef enum logic [1:0] {
    StRunFast  = 2'b00,
    StPendSlow = 2'b01,
    StRunSlow  = 2'b10,
    StPendFast = 2'b11
  } rate_state_e;

  // A commit on slow_evt beats a simultaneous request; a request while idle is only queued.
  function automatic rate_state_e rate_fsm_next(rate_state_e st, logic req, logic slow_evt);
    rate_state_e nxt;
    nxt = st;
    unique case (st)
      StRunFast: begin
        if (req) nxt = StPendSlow;
      end
      StPendSlow: begin
        if (slow_evt) nxt = StRunSlow;
        else if (req) nxt = StRunFast;
      end
      StRunSlow: begin
        if (req) nxt = StPendFast;
      end
      StPendFast: begin
        if (slow_evt) nxt = StRunFast;
        else if (req) nxt = StRunSlow;
      end
    endcase
    return nxt;
  endfunction

  function automatic logic rate_is_slow(rate_state_e st);
    return (st == StRunSlow) || (st == StPendFast);
  endfunction

  function automatic logic rate_is_pending(rate_state_e st);
    return (st == StPendSlow) || (st == StPendFast);
  endfunction

endpackage

// File: rtl/tick_rate_controller_if.sv
// Control/status bundle between the tick rate controller and its user logic.
interface tick_rate_controller_if;
  logic en;
  logic btn_speed;
  logic tick;
  logic speed;
  logic pending;

  modport master (
    output en,
    output btn_speed,
    input  tick,
    input  speed,
    input  pending
  );

  modport slave (
    input  en,
    input  btn_speed,
    output tick,
    output speed,
    output pending
  );
endinterface

// File: rtl/tick_rate_controller_prescaler.sv
// Two-stage prescaler: base counter divides clk down to fast events, decade counter to slow events.
// Both counters freeze while en_i is low and are never cleared by rate changes.
module tick_rate_controller_prescaler #(
  parameter int unsigned DIV_FAST  = 10_000_000,
  parameter int unsigned SLOW_MULT = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic fast_evt_o,
  output logic slow_evt_o
);

  localparam int unsigned BaseW = $clog2(DIV_FAST);
  localparam int unsigned DecW  = $clog2(SLOW_MULT);
  localparam logic [BaseW-1:0] BaseLast = BaseW'(DIV_FAST - 1);
  localparam logic [DecW-1:0]  DecLast  = DecW'(SLOW_MULT - 1);

  logic [BaseW-1:0] base_q, base_d;
  logic [DecW-1:0]  dec_q, dec_d;
  logic             fast_evt;
  logic             slow_evt;

  assign fast_evt = en_i & (base_q == BaseLast);
  assign slow_evt = fast_evt & (dec_q == DecLast);

  always_comb begin
    base_d = base_q;
    dec_d  = dec_q;
    if (en_i) begin
      base_d = (base_q == BaseLast) ? '0 : base_q + 1'b1;
    end
    if (fast_evt) begin
      dec_d = (dec_q == DecLast) ? '0 : dec_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
      dec_q  <= '0;
    end else begin
      base_q <= base_d;
      dec_q  <= dec_d;
    end
  end

  assign fast_evt_o = fast_evt;
  assign slow_evt_o = slow_evt;

endmodule

// File: rtl/tick_rate_controller.sv
// Tick rate controller: emits a registered one-cycle tick at 10 Hz or 1 Hz and switches rate
// only on a slow-period boundary so no tick is lost or duplicated across the change.
module tick_rate_controller
  import tick_rate_controller_pkg::*;
#(
  parameter int unsigned DIV_FAST  = 10_000_000,
  parameter int unsigned SLOW_MULT = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  tick_rate_controller_if.slave        bus
);

  logic        fast_evt;
  logic        slow_evt;
  logic        req;
  logic        btn_prev_q;
  logic        tick_q;
  logic        speed_q;
  logic        pending_q;
  rate_state_e state_q, state_d;

  tick_rate_controller_prescaler #(
    .DIV_FAST  (DIV_FAST),
    .SLOW_MULT (SLOW_MULT)
  ) u_prescaler (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (bus.en),
    .fast_evt_o (fast_evt),
    .slow_evt_o (slow_evt)
  );

  // btn_prev resets high so a button held through reset does not look like a fresh press.
  assign req     = bus.btn_speed & ~btn_prev_q;
  assign state_d = rate_fsm_next(state_q, req, slow_evt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRunFast;
      speed_q    <= 1'b0;
      pending_q  <= 1'b0;
      tick_q     <= 1'b0;
      btn_prev_q <= 1'b1;
    end else begin
      btn_prev_q <= bus.btn_speed;
      // On a commit cycle slow_evt implies fast_evt, so the old speed gives the right tick.
      tick_q     <= speed_q ? slow_evt : fast_evt;
      state_q    <= state_d;
      speed_q    <= rate_is_slow(state_d);
      pending_q  <= rate_is_pending(state_d);
    end
  end

  assign bus.tick    = tick_q;
  assign bus.speed   = speed_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_tick_rate_controller.sv
// Bench for tick_rate_controller with DIV_FAST=4, SLOW_MULT=10: per-cycle scoreboard plus
// hand-derived spot vectors and a few multi-cycle corner sequences.
module tb_tick_rate_controller;

  localparam int unsigned DivFast  = 4;
  localparam int unsigned SlowMult = 10;
  localparam int unsigned SlowPer  = DivFast * SlowMult;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tick_rate_controller_if bus_if ();

  tick_rate_controller #(
    .DIV_FAST  (DivFast),
    .SLOW_MULT (SlowMult)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic tick;
    logic speed;
    logic pending;
  } exp_t;

  typedef struct {
    int         scen;
    int         cyc;
    logic [2:0] tsp;
  } spot_t;

  exp_t       sb_q[$];
  spot_t      spots[$];
  logic [2:0] hist[200];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: one enabled-cycle phase counter instead of cascaded counters.
  int   m_act;
  logic m_speed, m_pend, m_tick, m_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic b);
    logic fast, slow, req;
    if (r) begin
      m_act = 0; m_speed = 1'b0; m_pend = 1'b0; m_tick = 1'b0; m_prev = 1'b1;
    end else begin
      fast   = e && ((m_act % DivFast) == DivFast - 1);
      slow   = e && (m_act == SlowPer - 1);
      req    = b && !m_prev;
      m_tick = m_speed ? slow : fast;
      if (m_pend) begin
        if (slow) begin
          m_speed = !m_speed;
          m_pend  = 1'b0;
        end else if (req) begin
          m_pend = 1'b0;
        end
      end else if (req) begin
        m_pend = 1'b1;
      end
      m_prev = b;
      if (e) m_act = (m_act + 1) % SlowPer;
    end
  endtask

  task automatic run_cycle(input logic r, input logic e, input logic b);
    exp_t want, got;
    rst = r;
    bus_if.en = e;
    bus_if.btn_speed = b;
    model_step(r, e, b);
    sb_q.push_back('{m_tick, m_speed, m_pend});
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    got  = '{bus_if.tick, bus_if.speed, bus_if.pending};
    cyc  = r ? 0 : cyc + 1;
    if (cyc < 200) hist[cyc] = got;
    check($sformatf("sb cyc%0d {tick,speed,pend}", cyc), 32'(got), 32'(want));
  endtask

  function automatic void stim(input int s, input int c, output logic e, output logic b);
    e = 1'b1;
    b = 1'b0;
    case (s)
      2: b = (c >= 10);
      3: b = (c >= 10 && c < 14) || (c >= 18);
      4: e = !(c >= 5 && c <= 11);
      5: b = (c < 5) || (c >= 10 && c < 12) || (c >= 39 && c < 60) || (c >= 79);
      default: ;
    endcase
  endfunction

  task automatic run_scen(input int s, input logic rst_btn, input int ncyc);
    logic e, b;
    run_cycle(1'b1, 1'b0, rst_btn);
    run_cycle(1'b1, 1'b0, rst_btn);
    for (int c = 0; c < ncyc; c++) begin
      stim(s, c, e, b);
      run_cycle(1'b0, e, b);
    end
    foreach (spots[i]) begin
      if (spots[i].scen == s) begin
        check($sformatf("spot s%0d c%0d {tick,speed,pend}", s, spots[i].cyc),
              32'(hist[spots[i].cyc]), 32'(spots[i].tsp));
      end
    end
  endtask

  function automatic void add_spot(input int s, input int c, input logic [2:0] tsp);
    spots.push_back('{s, c, tsp});
  endfunction

  int ticks;

  initial begin
    rst = 1'b1;
    bus_if.en = 1'b0;
    bus_if.btn_speed = 1'b0;

    // {tick, speed, pending} expected at cycle c after reset release
    add_spot(2, 0, 3'b000);   add_spot(2, 4, 3'b100);   add_spot(2, 8, 3'b100);
    add_spot(2, 10, 3'b000);  add_spot(2, 11, 3'b001);  add_spot(2, 12, 3'b101);
    add_spot(2, 39, 3'b001);  add_spot(2, 40, 3'b110);  add_spot(2, 44, 3'b010);
    add_spot(2, 76, 3'b010);  add_spot(2, 80, 3'b110);  add_spot(2, 120, 3'b110);
    add_spot(3, 15, 3'b001);  add_spot(3, 16, 3'b101);  add_spot(3, 18, 3'b001);
    add_spot(3, 19, 3'b000);  add_spot(3, 20, 3'b100);  add_spot(3, 40, 3'b100);
    add_spot(3, 44, 3'b100);
    add_spot(4, 4, 3'b100);   add_spot(4, 8, 3'b000);   add_spot(4, 12, 3'b000);
    add_spot(4, 15, 3'b100);  add_spot(4, 16, 3'b000);  add_spot(4, 19, 3'b100);
    add_spot(5, 3, 3'b000);   add_spot(5, 11, 3'b001);  add_spot(5, 39, 3'b001);
    add_spot(5, 40, 3'b110);  add_spot(5, 41, 3'b010);  add_spot(5, 79, 3'b010);
    add_spot(5, 80, 3'b111);  add_spot(5, 119, 3'b011); add_spot(5, 120, 3'b100);
    add_spot(5, 124, 3'b100);

    run_scen(2, 1'b0, 125);
    ticks = 0;
    for (int c = 41; c <= 79; c++) ticks += int'(hist[c][2]);
    check("no slow-rate tick in 41..79", 32'(ticks), 32'd0);

    run_scen(3, 1'b0, 60);

    run_scen(4, 1'b0, 30);
    ticks = 0;
    for (int c = 5; c <= 14; c++) ticks += int'(hist[c][2]);
    check("no tick while paused 5..14", 32'(ticks), 32'd0);

    run_scen(5, 1'b1, 126);

    // Reset while a slow request is pending
    run_cycle(1'b1, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) run_cycle(1'b0, 1'b1, c >= 10);
    check("pre-rst {tick,speed,pend}",
          32'({bus_if.tick, bus_if.speed, bus_if.pending}), 32'(3'b101));
    run_cycle(1'b1, 1'b1, 1'b1);
    check("post-rst {tick,speed,pend}",
          32'({bus_if.tick, bus_if.speed, bus_if.pending}), 32'(3'b000));
    check("post-rst base_cnt", 32'(dut.u_prescaler.base_q), 32'd0);
    check("post-rst dec_cnt", 32'(dut.u_prescaler.dec_q), 32'd0);
    for (int c = 0; c < 45; c++) run_cycle(1'b0, 1'b1, 1'b1);
    check("request lost after rst {speed,pend}",
          32'({bus_if.speed, bus_if.pending}), 32'(2'b00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
